// File: rtl/alu_op_issue.sv
// alu_op_issue
// Opcode issue stage feeding the 4-to-16 decoder of the ALU datapath.
// Opcodes from the control path are buffered in a small circular FIFO and
// presented to the decoder one at a time. Single-cycle opcodes hold en_out
// for one cycle. Opcodes flagged in MULTI_MASK hold it for two cycles.
//
// Parameters
//   DEPTH      : FIFO depth in opcodes (power of 2, >= 2)
//   MULTI_MASK : bit n set -> opcode n executes for 2 cycles
//
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   in_valid   : in_op is valid this cycle
//   in_ready   : FIFO can accept an opcode this cycle
//   in_op      : opcode to queue
//   stall      : downstream hold, freezes issue progress
//   flush      : synchronous abort of the queue and the current opcode
//   sel_out    : decoder select
//   en_out     : decoder enable
//   done       : pulse on the final execute cycle of each opcode
//   busy       : opcode executing or queue non-empty
//   count      : current FIFO occupancy (0..DEPTH)

module alu_op_issue #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] MULTI_MASK = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic                     stall,
  input  logic                     flush,
  output logic [3:0]               sel_out,
  output logic                     en_out,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state;
  logic            remaining;  // extra execute cycles left for current op
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [3:0]      mem [DEPTH];
  logic [3:0]      head;
  logic            push;
  logic            pop;

  assign head = mem[rptr];

  // in_ready looks only at registered count: a pop in the same cycle does
  // not open a slot, which keeps the ready path short.
  assign in_ready = (count != FULL) && !flush;
  assign push     = in_valid && in_ready;

  // Pop on the first issue from IDLE, or back-to-back when the current
  // opcode completes. Flush suppresses any pop.
  assign pop = !flush && !stall && (count != '0) &&
               ((state == IDLE) || !remaining);

  assign en_out = (state == EXEC);
  assign done   = (state == EXEC) && !remaining && !stall && !flush;
  assign busy   = (state == EXEC) || (count != '0);

  // NOTE: the storage array has no reset; validity is tracked by the
  // pointers and count, so clearing the contents would only add logic.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_op;
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= 1'b0;
      sel_out   <= 4'h0;
    end else if (flush) begin
      state     <= IDLE;
      remaining <= 1'b0;
      sel_out   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sel_out   <= head;
            remaining <= MULTI_MASK[head];
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            if (remaining) begin
              remaining <= 1'b0;
            end else if (pop) begin
              sel_out   <= head;
              remaining <= MULTI_MASK[head];
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
